mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller that answers cache-block fetch requests from the instruction fetch unit and byte/half/word load/store requests from the load-store buffer, serialising both onto the single byte-wide RAM/IO port. It is the responder end of the fetch unit's `mem_find_valid`/`mem_find_addr` → `mem_data_valid`/`mem_data` protocol. It sits between the core's front/back ends and external memory.

## Interface
- `BLK_BYTES`, 64, bytes per instruction-cache block; must be a power of two.
- `ADDR_W`, 32, address width.
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `rdy`  in  1  global enable; low freezes all state.
- `rollback`  in  1  misprediction flush.
- `if_find_valid`  in  1  one-cycle request pulse from fetch.
- `if_find_addr`  in  ADDR_W  any address inside the wanted block.
- `if_data_valid`  out  1  one-cycle block-ready pulse.
- `if_data`  out  8*BLK_BYTES  block, byte k at bits [8k+7:8k].
- `lsb_valid`  in  1  one-cycle request pulse from LSB.
- `lsb_wr`  in  1  1 = store, 0 = load.
- `lsb_len`  in  2  00 byte, 01 half, 11 word (10 illegal, treated as word).
- `lsb_addr`  in  ADDR_W  first byte address.
- `lsb_wdata`  in  32  store data, little-endian.
- `lsb_done`  out  1  one-cycle completion pulse.
- `lsb_rdata`  out  32  load data, zero-extended.
- `mem_din`  in  8  RAM read byte, valid one cycle after address.
- `mem_dout`  out  8  RAM write byte.
- `mem_a`  out  ADDR_W  RAM address.
- `mem_wr`  out  1  1 = write.
- `io_buffer_full`  in  1  IO write back-pressure.

## Operation
- Reset: every output 0; state IDLE; both pending slots empty; counters 0.
- Requests are pulses. A pulse is latched into its client's pending slot (valid + fields) in any state; a later pulse from the same client overwrites its slot.
- States: IDLE, IF_READ, LS_READ, LS_WRITE.
- IDLE: if LSB slot (or same-cycle `lsb_valid`) valid → LS_READ/LS_WRITE; else if IF slot valid → IF_READ. LSB has priority; simultaneous pulses serve LSB first, IF stays pending. Slot cleared on dispatch.
- IF_READ: base = addr with low log2(BLK_BYTES) bits cleared. Issue `mem_a` = base+0 … base+BLK_BYTES-1, one per cycle, `mem_wr`=0. Capture `mem_din` one cycle after each address. After last byte captured: `if_data_valid`=1 for one cycle with full `if_data`, return to IDLE.
- LS_READ: issue lsb_addr+0 … +(n-1), n = 1/2/4; capture byte k into `lsb_rdata`[8k+7:8k], upper bytes 0. Then `lsb_done` pulse, IDLE.
- LS_WRITE: each cycle `mem_wr`=1, `mem_a`=addr+k, `mem_dout`=wdata byte k. If `io_buffer_full`=1 and addr[17:16]==2'b11, issue nothing (`mem_wr`=0) and hold k. After last byte written: `lsb_done` pulse, IDLE.
- Byte counter 7 bits, counts 0..BLK_BYTES; addresses wrap modulo 2^ADDR_W.
- `rollback`: abort IF_READ and LS_READ (no valid/done pulse), clear both pending slots, go IDLE next cycle. LS_WRITE is never aborted; it completes and pulses `lsb_done`. A request pulse in the rollback cycle is dropped.
- `rdy`=0: no state change, `mem_wr` forced 0, pulses not emitted; pulses arriving are ignored.
- `mem_wr` is 0 in every cycle not issuing a write.

## Timing
- Request pulse at edge E0 (IDLE, nothing pending): first address driven in cycle after E0.
- IF block: addresses in cycles 1..64, last byte captured end of cycle 65, `if_data_valid` high cycle 66; next request can start addressing cycle 67.
- Load of n bytes: `lsb_done` in cycle n+2. Store of n bytes, no stall: `lsb_done` in cycle n+1.
- `if_data`/`lsb_rdata` stable from the done pulse until the next transaction of the same client begins.

## Test plan
- Fetch pulse addr 0x1234 with RAM preloaded byte i = i&0xFF: `mem_a` 0x1200..0x123F, `if_data_valid` at cycle 66, byte k of `if_data` = 0x00+k.
- Load word at 0x100 (bytes 11 22 33 44): `lsb_rdata`=0x44332211, `lsb_done` cycle 6; byte load at 0x103 → 0x00000044.
- Store word 0xDEADBEEF at 0x30000 with `io_buffer_full` high 3 cycles: no write until released, then EF,BE,AD,DE at 0x30000..3, `lsb_done` once.
- Fetch and load pulses same cycle: load served and done first, then fetch block delivered.
- Rollback at cycle 20 of IF_READ: no `if_data_valid`; IDLE next cycle; subsequent fetch returns correct block.
- Async `rst` mid-store: all outputs 0 immediately, `mem_wr`=0, no `lsb_done`.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the fetch, load-store and RAM/IO signals around mem_ctrl.
//   slave  : the controller side (mem_ctrl)
//   master : the environment side (fetch unit, LSB, RAM/IO)
// Signals:
//   rdy, rollback                       global enable / misprediction flush
//   if_find_valid/addr                  block fetch request pulse + address
//   if_data_valid/if_data               block-ready pulse + block (byte k at [8k+7:8k])
//   lsb_valid/wr/len/addr/wdata         load/store request pulse + fields
//   lsb_done/lsb_rdata                  completion pulse + zero-extended load data
//   mem_din/mem_dout/mem_a/mem_wr       byte-wide RAM/IO port
//   io_buffer_full                      IO write back-pressure
interface mem_ctrl_if #(
    parameter int BLK_BYTES = 64,
    parameter int ADDR_W    = 32
);
    logic                     rdy;
    logic                     rollback;
    logic                     if_find_valid;
    logic [ADDR_W-1:0]        if_find_addr;
    logic                     if_data_valid;
    logic [8*BLK_BYTES-1:0]   if_data;
    logic                     lsb_valid;
    logic                     lsb_wr;
    logic [1:0]               lsb_len;
    logic [ADDR_W-1:0]        lsb_addr;
    logic [31:0]              lsb_wdata;
    logic                     lsb_done;
    logic [31:0]              lsb_rdata;
    logic [7:0]               mem_din;
    logic [7:0]               mem_dout;
    logic [ADDR_W-1:0]        mem_a;
    logic                     mem_wr;
    logic                     io_buffer_full;

    modport slave (
        input  rdy, rollback,
        input  if_find_valid, if_find_addr,
        output if_data_valid, if_data,
        input  lsb_valid, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        output lsb_done, lsb_rdata,
        input  mem_din, io_buffer_full,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, rollback,
        output if_find_valid, if_find_addr,
        input  if_data_valid, if_data,
        output lsb_valid, lsb_wr, lsb_len, lsb_addr, lsb_wdata,
        input  lsb_done, lsb_rdata,
        output mem_din, io_buffer_full,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises instruction-cache block fetches and LSB byte/half/word
// loads/stores onto one byte-wide RAM/IO port. LSB requests win over fetches.
// Ports:
//   clk  single clock, rising edge
//   rst  asynchronous active-high reset
//   bus  mem_ctrl_if.slave (fetch, LSB and RAM/IO signals)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | no transfer; dispatch pending LSB request, else pending fetch
// IF_READ  | reading BLK_BYTES bytes of an aligned block into if_data
// LS_READ  | reading 1/2/4 bytes into lsb_rdata
// LS_WRITE | writing 1/2/4 bytes; stalls on full IO buffer, never aborted
module mem_ctrl #(
    parameter int BLK_BYTES = 64,
    parameter int ADDR_W    = 32
) (
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    localparam int                OFF_W    = $clog2(BLK_BYTES);
    localparam logic [6:0]        BLK_N    = 7'(BLK_BYTES);
    localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'(BLK_BYTES - 1);

    typedef enum logic [1:0] {IDLE, IF_READ, LS_READ, LS_WRITE} state_t;

    state_t                 state;

    logic                   if_slot_v;
    logic [ADDR_W-1:0]      if_slot_addr;
    logic                   ls_slot_v;
    logic                   ls_slot_wr;
    logic [1:0]             ls_slot_len;
    logic [ADDR_W-1:0]      ls_slot_addr;
    logic [31:0]            ls_slot_wdata;

    logic [ADDR_W-1:0]      op_addr;
    logic [6:0]             op_n;
    logic [31:0]            op_wdata;
    logic [6:0]             cnt;      // addresses issued (reads) / bytes written (stores)
    logic [6:0]             cap;      // bytes captured
    logic                   iss;      // a read address is on mem_a this cycle
    logic                   rd_pend;  // mem_din carries the byte for last cycle's address

    logic [ADDR_W-1:0]      mem_a_q;
    logic [7:0]             mem_dout_q;
    logic                   mem_wr_q;
    logic                   if_valid_q;
    logic [8*BLK_BYTES-1:0] if_data_q;
    logic                   lsb_done_q;
    logic [31:0]            lsb_rdata_q;

    function automatic logic [6:0] len_n(input logic [1:0] len);
        case (len)
            2'b00:   return 7'd1;
            2'b01:   return 7'd2;
            default: return 7'd4;
        endcase
    endfunction

    // A same-cycle pulse is newer than anything in the slot, so it wins.
    logic                   ls_req;
    logic                   ls_wr_e;
    logic [1:0]             ls_len_e;
    logic [ADDR_W-1:0]      ls_addr_e;
    logic [31:0]            ls_wdata_e;
    logic                   if_req;
    logic [ADDR_W-1:0]      if_base_e;
    logic [6:0]             wr_k;
    logic [ADDR_W-1:0]      wr_a;

    assign ls_req     = bus.lsb_valid | ls_slot_v;
    assign ls_wr_e    = bus.lsb_valid ? bus.lsb_wr    : ls_slot_wr;
    assign ls_len_e   = bus.lsb_valid ? bus.lsb_len   : ls_slot_len;
    assign ls_addr_e  = bus.lsb_valid ? bus.lsb_addr  : ls_slot_addr;
    assign ls_wdata_e = bus.lsb_valid ? bus.lsb_wdata : ls_slot_wdata;
    assign if_req     = bus.if_find_valid | if_slot_v;
    assign if_base_e  = (bus.if_find_valid ? bus.if_find_addr : if_slot_addr) & ~OFF_MASK;

    // Next store byte: advance only if this cycle's write actually went out.
    assign wr_k = cnt + {6'd0, mem_wr_q};
    assign wr_a = op_addr + ADDR_W'(wr_k);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            if_slot_v     <= 1'b0;
            if_slot_addr  <= '0;
            ls_slot_v     <= 1'b0;
            ls_slot_wr    <= 1'b0;
            ls_slot_len   <= '0;
            ls_slot_addr  <= '0;
            ls_slot_wdata <= '0;
            op_addr       <= '0;
            op_n          <= '0;
            op_wdata      <= '0;
            cnt           <= '0;
            cap           <= '0;
            iss           <= 1'b0;
            rd_pend       <= 1'b0;
            mem_a_q       <= '0;
            mem_dout_q    <= '0;
            mem_wr_q      <= 1'b0;
            if_valid_q    <= 1'b0;
            if_data_q     <= '0;
            lsb_done_q    <= 1'b0;
            lsb_rdata_q   <= '0;
        end else if (bus.rdy) begin
            if_valid_q <= 1'b0;
            lsb_done_q <= 1'b0;

            if (bus.rollback) begin
                if_slot_v <= 1'b0;
                ls_slot_v <= 1'b0;
            end else begin
                if (bus.if_find_valid) begin
                    if_slot_v    <= 1'b1;
                    if_slot_addr <= bus.if_find_addr;
                end
                if (bus.lsb_valid) begin
                    ls_slot_v     <= 1'b1;
                    ls_slot_wr    <= bus.lsb_wr;
                    ls_slot_len   <= bus.lsb_len;
                    ls_slot_addr  <= bus.lsb_addr;
                    ls_slot_wdata <= bus.lsb_wdata;
                end
            end

            case (state)
                IDLE: begin
                    mem_wr_q <= 1'b0;
                    rd_pend  <= 1'b0;
                    cap      <= '0;
                    if (!bus.rollback) begin
                        if (ls_req) begin
                            ls_slot_v <= 1'b0;
                            op_addr   <= ls_addr_e;
                            op_n      <= len_n(ls_len_e);
                            op_wdata  <= ls_wdata_e;
                            mem_a_q   <= ls_addr_e;
                            if (ls_wr_e) begin
                                state      <= LS_WRITE;
                                cnt        <= '0;
                                mem_dout_q <= ls_wdata_e[7:0];
                                mem_wr_q   <= !(bus.io_buffer_full && ls_addr_e[17:16] == 2'b11);
                            end else begin
                                state       <= LS_READ;
                                cnt         <= 7'd1;
                                iss         <= 1'b1;
                                lsb_rdata_q <= '0;
                            end
                        end else if (if_req) begin
                            if_slot_v <= 1'b0;
                            state     <= IF_READ;
                            op_addr   <= if_base_e;
                            op_n      <= BLK_N;
                            mem_a_q   <= if_base_e;
                            cnt       <= 7'd1;
                            iss       <= 1'b1;
                        end
                    end
                end

                IF_READ, LS_READ: begin
                    if (bus.rollback) begin
                        state   <= IDLE;
                        iss     <= 1'b0;
                        rd_pend <= 1'b0;
                    end else begin
                        rd_pend <= iss;
                        if (cnt < op_n) begin
                            mem_a_q <= op_addr + ADDR_W'(cnt);
                            cnt     <= cnt + 7'd1;
                            iss     <= 1'b1;
                        end else begin
                            iss <= 1'b0;
                        end
                        if (rd_pend) begin
                            if (state == IF_READ)
                                if_data_q[{cap[OFF_W-1:0], 3'b000} +: 8] <= bus.mem_din;
                            else
                                lsb_rdata_q[{cap[1:0], 3'b000} +: 8] <= bus.mem_din;
                            cap <= cap + 7'd1;
                            if (cap == op_n - 7'd1) begin
                                state   <= IDLE;
                                iss     <= 1'b0;
                                rd_pend <= 1'b0;
                                if (state == IF_READ)
                                    if_valid_q <= 1'b1;
                                else
                                    lsb_done_q <= 1'b1;
                            end
                        end
                    end
                end

                LS_WRITE: begin
                    if (mem_wr_q)
                        cnt <= cnt + 7'd1;
                    if (mem_wr_q && cnt == op_n - 7'd1) begin
                        mem_wr_q   <= 1'b0;
                        lsb_done_q <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        mem_a_q    <= wr_a;
                        mem_dout_q <= op_wdata[{wr_k[1:0], 3'b000} +: 8];
                        mem_wr_q   <= !(bus.io_buffer_full && wr_a[17:16] == 2'b11);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    // While rdy is low the state is frozen; gating keeps a frozen write or
    // pulse from reaching the outside until rdy returns.
    assign bus.mem_wr        = mem_wr_q & bus.rdy;
    assign bus.if_data_valid = if_valid_q & bus.rdy;
    assign bus.lsb_done      = lsb_done_q & bus.rdy;
    assign bus.mem_a         = mem_a_q;
    assign bus.mem_dout      = mem_dout_q;
    assign bus.if_data       = if_data_q;
    assign bus.lsb_rdata     = lsb_rdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a byte RAM model.
// Unwritten RAM bytes read back as the low address byte.
module tb_mem_ctrl;
    localparam int BLK_BYTES = 64;
    localparam int ADDR_W    = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_ctrl_if #(.BLK_BYTES(BLK_BYTES), .ADDR_W(ADDR_W)) bus ();

    mem_ctrl #(.BLK_BYTES(BLK_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  ram [logic [31:0]];
    int          cyc;
    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] wa_q [$];
    logic [7:0]  wd_q [$];
    int          wc_q [$];

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram.exists(a))
            return ram[a];
        return a[7:0];
    endfunction

    always @(posedge clk) begin
        bus.mem_din <= ram_rd(bus.mem_a);
        if (bus.mem_wr === 1'b1) begin
            ram[bus.mem_a] = bus.mem_dout;
            wa_q.push_back(bus.mem_a);
            wd_q.push_back(bus.mem_dout);
            wc_q.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clr_log();
        wa_q.delete();
        wd_q.delete();
        wc_q.delete();
    endtask

    function automatic logic [39:0] log_at(input int i);
        if (i < wa_q.size())
            return {wa_q[i], wd_q[i]};
        return '1;
    endfunction

    function automatic logic [511:0] blk_exp(input logic [31:0] base);
        logic [511:0] v;
        for (int k = 0; k < BLK_BYTES; k++)
            v[8*k +: 8] = ram_rd(base + 32'(k));
        return v;
    endfunction

    task automatic req_if(input logic [31:0] a);
        bus.if_find_valid = 1'b1;
        bus.if_find_addr  = a;
        cyc = 0;
        step();
        bus.if_find_valid = 1'b0;
    endtask

    task automatic req_ls(input logic wr, input logic [1:0] len, input logic [31:0] a,
                          input logic [31:0] d);
        bus.lsb_valid = 1'b1;
        bus.lsb_wr    = wr;
        bus.lsb_len   = len;
        bus.lsb_addr  = a;
        bus.lsb_wdata = d;
        cyc = 0;
        step();
        bus.lsb_valid = 1'b0;
    endtask

    // which: 0 if_data_valid, 1 lsb_done, 2 either. at = cycle seen, -1 if none.
    task automatic wait_sig(input int which, input int max, output int at);
        at = -1;
        for (int i = 0; i < max; i++) begin
            if ((which == 0 && bus.if_data_valid === 1'b1) ||
                (which == 1 && bus.lsb_done === 1'b1) ||
                (which == 2 && (bus.if_data_valid === 1'b1 || bus.lsb_done === 1'b1))) begin
                at = cyc;
                break;
            end
            step();
        end
    endtask

    initial begin
        int at;
        int bad;

        bus.rdy            = 1'b1;
        bus.rollback       = 1'b0;
        bus.if_find_valid  = 1'b0;
        bus.if_find_addr   = '0;
        bus.lsb_valid      = 1'b0;
        bus.lsb_wr         = 1'b0;
        bus.lsb_len        = 2'b00;
        bus.lsb_addr       = '0;
        bus.lsb_wdata      = '0;
        bus.io_buffer_full = 1'b0;
        ram[32'h100] = 8'h11;
        ram[32'h101] = 8'h22;
        ram[32'h102] = 8'h33;
        ram[32'h103] = 8'h44;
        cyc = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_wr", bus.mem_wr, 0);
        chk("rst_mem_a", bus.mem_a, 0);
        chk("rst_if_valid", bus.if_data_valid, 0);
        chk("rst_if_data", bus.if_data, 0);
        chk("rst_lsb_done", bus.lsb_done, 0);
        chk("rst_lsb_rdata", bus.lsb_rdata, 0);
        #3;
        rst = 1'b0;
        step();

        // block fetch, addresses and latency
        req_if(32'h1234);
        bad = 0;
        for (int c = 1; c <= 64; c++) begin
            if (bus.mem_a !== 32'h1200 + 32'(c - 1) || bus.mem_wr !== 1'b0)
                bad++;
            step();
        end
        chk("if_addr_seq", bad, 0);
        chk("if_valid_c65", bus.if_data_valid, 0);
        step();
        chk("if_valid_c66", bus.if_data_valid, 1);
        chk("if_data_1200", bus.if_data, blk_exp(32'h1200));
        step();
        chk("if_valid_c67", bus.if_data_valid, 0);

        // loads
        req_ls(1'b0, 2'b11, 32'h100, 32'h0);
        chk("ld_w_a0", bus.mem_a, 32'h100);
        wait_sig(1, 20, at);
        chk("ld_w_cyc", at, 6);
        chk("ld_w_data", bus.lsb_rdata, 32'h44332211);
        req_ls(1'b0, 2'b00, 32'h103, 32'h0);
        wait_sig(1, 20, at);
        chk("ld_b_cyc", at, 3);
        chk("ld_b_data", bus.lsb_rdata, 32'h00000044);
        req_ls(1'b0, 2'b01, 32'h101, 32'h0);
        wait_sig(1, 20, at);
        chk("ld_h_cyc", at, 4);
        chk("ld_h_data", bus.lsb_rdata, 32'h00003322);

        // half store without stall, then read it back
        clr_log();
        req_ls(1'b1, 2'b01, 32'h200, 32'h0000_1234);
        chk("st_h_wr_c1", bus.mem_wr, 1);
        wait_sig(1, 20, at);
        chk("st_h_cyc", at, 3);
        chk("st_h_cnt", wa_q.size(), 2);
        chk("st_h_b0", log_at(0), {32'h200, 8'h34});
        chk("st_h_b1", log_at(1), {32'h201, 8'h12});
        req_ls(1'b0, 2'b01, 32'h200, 32'h0);
        wait_sig(1, 20, at);
        chk("ld_back", bus.lsb_rdata, 32'h00001234);

        // word store into IO space held off by a full buffer for 3 cycles
        clr_log();
        bus.io_buffer_full = 1'b1;
        req_ls(1'b1, 2'b11, 32'h30000, 32'hDEADBEEF);
        bad = 0;
        if (bus.mem_wr !== 1'b0) bad++;
        step();
        if (bus.mem_wr !== 1'b0) bad++;
        step();
        if (bus.mem_wr !== 1'b0) bad++;
        bus.io_buffer_full = 1'b0;
        chk("st_io_stall", bad, 0);
        wait_sig(1, 20, at);
        chk("st_io_cyc", at, 8);
        chk("st_io_cnt", wa_q.size(), 4);
        chk("st_io_first", wc_q.size() > 0 ? wc_q[0] : -1, 4);
        chk("st_io_b0", log_at(0), {32'h30000, 8'hEF});
        chk("st_io_b1", log_at(1), {32'h30001, 8'hBE});
        chk("st_io_b2", log_at(2), {32'h30002, 8'hAD});
        chk("st_io_b3", log_at(3), {32'h30003, 8'hDE});
        step();
        wait_sig(1, 10, at);
        chk("st_io_once", at, -1);

        // simultaneous fetch and load: load first, fetch stays pending
        bus.if_find_valid = 1'b1;
        bus.if_find_addr  = 32'h4050;
        bus.lsb_valid     = 1'b1;
        bus.lsb_wr        = 1'b0;
        bus.lsb_len       = 2'b11;
        bus.lsb_addr      = 32'h100;
        cyc = 0;
        step();
        bus.if_find_valid = 1'b0;
        bus.lsb_valid     = 1'b0;
        wait_sig(2, 100, at);
        chk("both_ld_cyc", at, 6);
        chk("both_ld_done", bus.lsb_done, 1);
        chk("both_ld_data", bus.lsb_rdata, 32'h44332211);
        step();
        wait_sig(0, 100, at);
        chk("both_if_cyc", at, 72);
        chk("both_if_data", bus.if_data, blk_exp(32'h4040));

        // rollback mid-fetch drops the fetch and the pending load
        req_if(32'h2000);
        while (cyc < 10) step();
        bus.lsb_valid = 1'b1;
        bus.lsb_wr    = 1'b0;
        bus.lsb_len   = 2'b11;
        bus.lsb_addr  = 32'h100;
        step();
        bus.lsb_valid = 1'b0;
        while (cyc < 20) step();
        bus.rollback = 1'b1;
        step();
        bus.rollback = 1'b0;
        req_if(32'h50A5);
        wait_sig(2, 100, at);
        chk("rb_if_cyc", at, 66);
        chk("rb_no_done", bus.lsb_done, 0);
        chk("rb_if_data", bus.if_data, blk_exp(32'h5080));

        // rdy low freezes the store and masks mem_wr
        clr_log();
        req_ls(1'b1, 2'b00, 32'h400, 32'h0000_005A);
        chk("rdy_wr_c1", bus.mem_wr, 1);
        bus.rdy = 1'b0;
        #1;
        chk("rdy_wr_gated", bus.mem_wr, 0);
        step();
        step();
        bus.rdy = 1'b1;
        wait_sig(1, 20, at);
        chk("rdy_cyc", at, 4);
        chk("rdy_cnt", wa_q.size(), 1);
        chk("rdy_b0", log_at(0), {32'h400, 8'h5A});

        // async reset in the middle of a store
        req_ls(1'b1, 2'b11, 32'h300, 32'hCAFEF00D);
        step();
        chk("ar_wr_before", bus.mem_wr, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_mem_wr", bus.mem_wr, 0);
        chk("ar_mem_a", bus.mem_a, 0);
        chk("ar_mem_dout", bus.mem_dout, 0);
        chk("ar_lsb_rdata", bus.lsb_rdata, 0);
        chk("ar_if_data", bus.if_data, 0);
        chk("ar_if_valid", bus.if_data_valid, 0);
        #1;
        rst = 1'b0;
        step();
        wait_sig(1, 10, at);
        chk("ar_no_done", at, -1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
